axis_video_sink: RTL

//  - AXI4-Stream video receiver: the consuming end of the stream that video_gen produces.
//  - Accepts 24-bit RGB beats with tuser = SOF and tlast = EOL.
//  - Recovers pixel_x/pixel_y and emits RGB444 per pixel.
//  - Checks frame structure, counts frames and errors.
//  - Used for loopback checking and frame capture alongside the HDMI output path.

---
 rtl/starsoc_params.sv | 12 +
 rtl/axis_video_sink.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/starsoc_params.sv
// rtl/starsoc_params.sv - shared display constants and video sink state type
package starsoc_params;

  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } sink_state_t;

endpackage

// File: rtl/axis_video_sink.sv
// rtl/axis_video_sink.sv - AXI4-Stream video receiver with frame structure checking
module axis_video_sink
  import starsoc_params::*;
#(
  parameter int H_ACTIVE = H_DISPLAY,
  parameter int V_ACTIVE = V_DISPLAY,
  parameter int DATA_W   = 24
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              throttle,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tuser,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              pix_valid,
  output logic [9:0]        pix_x,
  output logic [9:0]        pix_y,
  output logic [11:0]       rgb444,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              sof_err,
  output logic              eol_early,
  output logic              eol_late,
  output logic [15:0]       drop_count
);

  // Coordinates are 10 bits wide, so larger rasters cannot be represented.
  if (H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_param_check
    $error("axis_video_sink: H_ACTIVE and V_ACTIVE must not exceed 1024");
  end

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  sink_state_t state, state_nxt;
  logic [9:0]  x, y, x_nxt, y_nxt;
  logic [9:0]  emit_x, emit_y;
  logic        xfer, emit, drop_inc;
  logic        sof_err_nxt, eol_early_nxt, eol_late_nxt, frame_done_nxt;
  logic        x_last, y_last;
  logic        unused_tdata_bits;

  // Only the top nibble of each colour channel reaches rgb444.
  assign unused_tdata_bits = ^{s_tdata[19:16], s_tdata[11:8], s_tdata[3:0]};

  assign s_tready = enable & ~throttle & ~reset;
  assign xfer     = s_tvalid & s_tready;
  assign x_last   = (x == X_LAST);
  assign y_last   = (y == Y_LAST);

  // State register: reset always drops any partial frame.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) state <= WAIT_SOF;
    else       state <= state_nxt;
  end

  // Next state, next coordinates and the frame structure checker.
  always_comb begin
    state_nxt      = state;
    x_nxt          = x;
    y_nxt          = y;
    emit           = 1'b0;
    emit_x         = x;
    emit_y         = y;
    drop_inc       = 1'b0;
    sof_err_nxt    = 1'b0;
    eol_early_nxt  = 1'b0;
    eol_late_nxt   = 1'b0;
    frame_done_nxt = 1'b0;
    if (xfer) begin
      case (state)
        WAIT_SOF: begin
          if (s_tuser) begin
            emit      = 1'b1;
            emit_x    = 10'd0;
            emit_y    = 10'd0;
            x_nxt     = 10'd1;
            y_nxt     = 10'd0;
            state_nxt = ACTIVE;
          end else begin
            drop_inc = 1'b1;
          end
        end
        ACTIVE: begin
          emit = 1'b1;
          if (s_tuser) begin
            sof_err_nxt = 1'b1;
            emit_x      = 10'd0;
            emit_y      = 10'd0;
            x_nxt       = 10'd1;
            y_nxt       = 10'd0;
          end else if (s_tlast != x_last) begin
            // Line ended in the wrong place; resync to the next row.
            eol_early_nxt = s_tlast;
            eol_late_nxt  = x_last;
            x_nxt         = 10'd0;
            y_nxt         = y + 10'd1;
            if (y_last) begin
              state_nxt = WAIT_SOF;
              y_nxt     = 10'd0;
            end
          end else if (x_last) begin
            x_nxt = 10'd0;
            y_nxt = y + 10'd1;
            if (y_last) begin
              frame_done_nxt = 1'b1;
              state_nxt      = WAIT_SOF;
              y_nxt          = 10'd0;
            end
          end else begin
            x_nxt = x + 10'd1;
          end
        end
        default: state_nxt = WAIT_SOF;
      endcase
    end
  end

  // Registered pixel outputs, pulses, coordinates and statistics.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      x           <= 10'd0;
      y           <= 10'd0;
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      rgb444      <= 12'd0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
      sof_err     <= 1'b0;
      eol_early   <= 1'b0;
      eol_late    <= 1'b0;
      drop_count  <= 16'd0;
    end else begin
      x          <= x_nxt;
      y          <= y_nxt;
      pix_valid  <= emit;
      frame_done <= frame_done_nxt;
      sof_err    <= sof_err_nxt;
      eol_early  <= eol_early_nxt;
      eol_late   <= eol_late_nxt;
      if (emit) begin
        pix_x  <= emit_x;
        pix_y  <= emit_y;
        rgb444 <= {s_tdata[23:20], s_tdata[15:12], s_tdata[7:4]};
      end
      if (frame_done_nxt) frame_count <= frame_count + 16'd1;
      if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

endmodule
